// File: rtl/net_pkg.sv
// Shared sizing, state encoding and weight-count helper for the two-layer
// fully-connected sequencer.
package net_pkg;

  localparam int N_IN_DEF  = 2;
  localparam int N_HID_DEF = 4;
  localparam int N_OUT_DEF = 2;
  localparam int WAW_DEF   = 5;
  localparam int AAW_DEF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_MAC   = 3'd2,
    ST_BIAS  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ACT   = 3'd5,
    ST_WB    = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  // Each neuron owns its fan-in weights followed by one bias word.
  function automatic int num_weights(input int n_in, input int n_hid, input int n_out);
    return n_hid * (n_in + 1) + n_out * (n_hid + 1);
  endfunction

  localparam int NUM_WEIGHTS = num_weights(N_IN_DEF, N_HID_DEF, N_OUT_DEF);

endpackage

// File: rtl/net_layer_sequencer_if.sv
// Control bundle between the sequencer (master) and the MAC/activation
// datapath plus the button/LED front end (slave).
interface net_layer_sequencer_if
  import net_pkg::*;
#(
  parameter int WAW = WAW_DEF,
  parameter int AAW = AAW_DEF
);

  logic           start;
  logic           busy;
  logic           done;
  logic [WAW-1:0] w_addr;
  logic [AAW-1:0] a_rd_addr;
  logic           a_rd_sel;
  logic           acc_clr;
  logic           acc_en;
  logic           bias_en;
  logic           act_en;
  logic           wr_en;
  logic           wr_sel;
  logic [AAW-1:0] wr_addr;

  modport master (
    input  start,
    output busy, done, w_addr, a_rd_addr, a_rd_sel, acc_clr, acc_en,
           bias_en, act_en, wr_en, wr_sel, wr_addr
  );

  modport slave (
    output start,
    input  busy, done, w_addr, a_rd_addr, a_rd_sel, acc_clr, acc_en,
           bias_en, act_en, wr_en, wr_sel, wr_addr
  );

endinterface

// File: rtl/net_addr_gen.sv
// Weight address, fan-in index, neuron index and layer counters, stepped by
// the sequencer FSM; also reports when the current k / j are the last ones.
module net_addr_gen
  import net_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_HID = N_HID_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int WAW   = WAW_DEF,
  parameter int AAW   = AAW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr_all,
  input  logic           i_w_inc,
  input  logic           i_k_clr,
  input  logic           i_k_inc,
  input  logic           i_j_inc,
  input  logic           i_layer_next,
  output logic [WAW-1:0] o_w_addr,
  output logic [AAW-1:0] o_k,
  output logic [AAW-1:0] o_j,
  output logic           o_layer,
  output logic           o_k_last,
  output logic           o_j_last
);

  localparam logic [AAW-1:0] K0_LAST = AAW'(N_IN - 1);
  localparam logic [AAW-1:0] K1_LAST = AAW'(N_HID - 1);
  localparam logic [AAW-1:0] J0_LAST = AAW'(N_HID - 1);
  localparam logic [AAW-1:0] J1_LAST = AAW'(N_OUT - 1);

  logic [WAW-1:0] r_w_addr;
  logic [AAW-1:0] r_k;
  logic [AAW-1:0] r_j;
  logic           r_layer;

  // Counter registers; a run start clears everything, otherwise each counter steps on its own control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w_addr <= '0;
      r_k      <= '0;
      r_j      <= '0;
      r_layer  <= 1'b0;
    end else if (i_clr_all) begin
      r_w_addr <= '0;
      r_k      <= '0;
      r_j      <= '0;
      r_layer  <= 1'b0;
    end else begin
      if (i_w_inc) r_w_addr <= r_w_addr + WAW'(1);
      if (i_k_clr)      r_k <= '0;
      else if (i_k_inc) r_k <= r_k + AAW'(1);
      if (i_layer_next) begin
        r_j     <= '0;
        r_layer <= 1'b1;
      end else if (i_j_inc) begin
        r_j <= r_j + AAW'(1);
      end
    end
  end

  // Fan-in and neuron-count limits depend on which layer is being computed.
  always_comb begin
    o_k_last = 1'b0;
    o_j_last = 1'b0;
    if (r_layer) begin
      o_k_last = (r_k == K1_LAST);
      o_j_last = (r_j == J1_LAST);
    end else begin
      o_k_last = (r_k == K0_LAST);
      o_j_last = (r_j == J0_LAST);
    end
  end

  assign o_w_addr = r_w_addr;
  assign o_k      = r_k;
  assign o_j      = r_j;
  assign o_layer  = r_layer;

endmodule

// File: rtl/net_layer_sequencer.sv
// Time-multiplexes one MAC/activation datapath over both layers, one neuron
// at a time: CLR, K x MAC, BIAS, DRAIN, ACT, WB.
module net_layer_sequencer
  import net_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_HID = N_HID_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int WAW   = WAW_DEF,
  parameter int AAW   = AAW_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  net_layer_sequencer_if.master bus
);

  state_t         r_state;
  state_t         w_next_state;
  logic           r_start_q;
  logic           r_armed;
  logic           r_busy, r_done, r_acc_clr, r_acc_en, r_bias_en, r_act_en, r_wr_en;
  logic           w_trigger, w_accept, w_w_inc, w_k_clr, w_k_inc, w_j_inc, w_layer_next;
  logic [WAW-1:0] w_w_addr;
  logic [AAW-1:0] w_k, w_j;
  logic           w_layer, w_k_last, w_j_last;

  // A button already held when reset releases is not a press: arm one cycle later.
  assign w_trigger = bus.start & ~r_start_q & r_armed;

  // Start edge detector and post-reset arming.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_start_q <= bus.start;
      r_armed   <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and counter controls.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_w_inc      = 1'b0;
    w_k_clr      = 1'b0;
    w_k_inc      = 1'b0;
    w_j_inc      = 1'b0;
    w_layer_next = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_trigger) begin
          w_accept     = 1'b1;
          w_next_state = ST_CLR;
        end else begin
          w_next_state = r_state;
        end
      end
      ST_CLR: begin
        w_k_clr      = 1'b1;
        w_next_state = ST_MAC;
      end
      ST_MAC: begin
        w_w_inc = 1'b1;
        w_k_inc = 1'b1;
        if (w_k_last) w_next_state = ST_BIAS;
        else          w_next_state = ST_MAC;
      end
      ST_BIAS: begin
        w_w_inc      = 1'b1;
        w_next_state = ST_DRAIN;
      end
      ST_DRAIN: w_next_state = ST_ACT;
      ST_ACT:   w_next_state = ST_WB;
      ST_WB: begin
        if (!w_j_last) begin
          w_j_inc      = 1'b1;
          w_next_state = ST_CLR;
        end else if (w_layer == 1'b0) begin
          w_layer_next = 1'b1;
          w_next_state = ST_CLR;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are valid throughout the named state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_acc_clr <= 1'b0;
      r_acc_en  <= 1'b0;
      r_bias_en <= 1'b0;
      r_act_en  <= 1'b0;
      r_wr_en   <= 1'b0;
    end else begin
      r_busy    <= (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);
      r_done    <= (w_next_state == ST_DONE);
      r_acc_clr <= (w_next_state == ST_CLR);
      // First MAC cycle only issues an address; its product lands one cycle later.
      r_acc_en  <= ((w_next_state == ST_MAC) && (r_state == ST_MAC)) ||
                   (w_next_state == ST_BIAS) || (w_next_state == ST_DRAIN);
      r_bias_en <= (w_next_state == ST_DRAIN);
      r_act_en  <= (w_next_state == ST_ACT);
      r_wr_en   <= (w_next_state == ST_WB);
    end
  end

  net_addr_gen #(
    .N_IN (N_IN),
    .N_HID(N_HID),
    .N_OUT(N_OUT),
    .WAW  (WAW),
    .AAW  (AAW)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr_all   (w_accept),
    .i_w_inc     (w_w_inc),
    .i_k_clr     (w_k_clr),
    .i_k_inc     (w_k_inc),
    .i_j_inc     (w_j_inc),
    .i_layer_next(w_layer_next),
    .o_w_addr    (w_w_addr),
    .o_k         (w_k),
    .o_j         (w_j),
    .o_layer     (w_layer),
    .o_k_last    (w_k_last),
    .o_j_last    (w_j_last)
  );

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.w_addr    = w_w_addr;
  assign bus.a_rd_addr = w_k;
  assign bus.a_rd_sel  = w_layer;
  assign bus.acc_clr   = r_acc_clr;
  assign bus.acc_en    = r_acc_en;
  assign bus.bias_en   = r_bias_en;
  assign bus.act_en    = r_act_en;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_sel    = w_layer;
  assign bus.wr_addr   = w_j;

endmodule

// File: tb/tb_net_layer_sequencer.sv
// Directed bench: expected per-cycle traces for a full run are tabulated from
// the layer sizes, then replayed against the default and a 2-1-1 instance.
module tb_net_layer_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  net_layer_sequencer_if #(.WAW(5), .AAW(3)) bus0 ();
  net_layer_sequencer_if #(.WAW(5), .AAW(3)) bus1 ();

  net_layer_sequencer #(.N_IN(2), .N_HID(4), .N_OUT(2), .WAW(5), .AAW(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  net_layer_sequencer #(.N_IN(2), .N_HID(1), .N_OUT(1), .WAW(5), .AAW(3)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  typedef struct {
    logic       start;
    logic       busy, done, acc_clr, acc_en, bias_en, act_en, wr_en;
    logic       w_chk;
    logic [4:0] w_addr;
    logic       rd_chk;
    logic [2:0] rd_addr;
    logic       rd_sel;
    logic [2:0] wr_addr;
    logic       wr_sel;
  } vec_t;

  typedef struct {
    logic       busy, done, acc_clr, acc_en, bias_en, act_en, wr_en, rd_sel, wr_sel;
    logic [4:0] w_addr;
    logic [2:0] rd_addr, wr_addr;
  } obs_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int s, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, s, act, exp);
    end
  endtask

  function automatic obs_t get_obs(input int which);
    obs_t o;
    if (which == 0) begin
      o.busy = bus0.busy; o.done = bus0.done; o.acc_clr = bus0.acc_clr;
      o.acc_en = bus0.acc_en; o.bias_en = bus0.bias_en; o.act_en = bus0.act_en;
      o.wr_en = bus0.wr_en; o.rd_sel = bus0.a_rd_sel; o.wr_sel = bus0.wr_sel;
      o.w_addr = bus0.w_addr; o.rd_addr = bus0.a_rd_addr; o.wr_addr = bus0.wr_addr;
    end else begin
      o.busy = bus1.busy; o.done = bus1.done; o.acc_clr = bus1.acc_clr;
      o.acc_en = bus1.acc_en; o.bias_en = bus1.bias_en; o.act_en = bus1.act_en;
      o.wr_en = bus1.wr_en; o.rd_sel = bus1.a_rd_sel; o.wr_sel = bus1.wr_sel;
      o.w_addr = bus1.w_addr; o.rd_addr = bus1.a_rd_addr; o.wr_addr = bus1.wr_addr;
    end
    return o;
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v.start = 1'b0; v.busy = 1'b1; v.done = 1'b0; v.acc_clr = 1'b0; v.acc_en = 1'b0;
    v.bias_en = 1'b0; v.act_en = 1'b0; v.wr_en = 1'b0; v.w_chk = 1'b0; v.w_addr = 5'd0;
    v.rd_chk = 1'b0; v.rd_addr = 3'd0; v.rd_sel = 1'b0; v.wr_addr = 3'd0; v.wr_sel = 1'b0;
    return v;
  endfunction

  // Button pattern: held for the first 5 edges, a second press while busy at cycle 20.
  task automatic add(input vec_t v);
    int s;
    s = tbl.size();
    v.start = (s < 4) || (s >= 19 && s < 23);
    tbl.push_back(v);
  endtask

  task automatic build(input int n_in, input int n_hid, input int n_out);
    vec_t v;
    int   base;
    int   kk;
    int   nn;
    base = 0;
    tbl.delete();
    for (int l = 0; l < 2; l++) begin
      kk = (l == 0) ? n_in : n_hid;
      nn = (l == 0) ? n_hid : n_out;
      for (int j = 0; j < nn; j++) begin
        v = blank(); v.acc_clr = 1'b1; add(v);
        for (int m = 0; m < kk; m++) begin
          v = blank(); v.w_chk = 1'b1; v.w_addr = 5'(base + m);
          v.rd_chk = 1'b1; v.rd_addr = 3'(m); v.rd_sel = (l == 1);
          v.acc_en = (m > 0); add(v);
        end
        v = blank(); v.w_chk = 1'b1; v.w_addr = 5'(base + kk); v.acc_en = 1'b1; add(v);
        v = blank(); v.acc_en = 1'b1; v.bias_en = 1'b1; add(v);
        v = blank(); v.act_en = 1'b1; add(v);
        v = blank(); v.wr_en = 1'b1; v.wr_sel = (l == 1); v.wr_addr = 3'(j); add(v);
        base += kk + 1;
      end
    end
    v = blank(); v.busy = 1'b0; v.done = 1'b1; add(v);
  endtask

  task automatic check_vec(input obs_t o, input vec_t v, input int s);
    check("busy", s, 32'(o.busy), 32'(v.busy));
    check("done", s, 32'(o.done), 32'(v.done));
    check("acc_clr", s, 32'(o.acc_clr), 32'(v.acc_clr));
    check("acc_en", s, 32'(o.acc_en), 32'(v.acc_en));
    check("bias_en", s, 32'(o.bias_en), 32'(v.bias_en));
    check("act_en", s, 32'(o.act_en), 32'(v.act_en));
    check("wr_en", s, 32'(o.wr_en), 32'(v.wr_en));
    if (v.w_chk) check("w_addr", s, 32'(o.w_addr), 32'(v.w_addr));
    if (v.rd_chk) begin
      check("a_rd_addr", s, 32'(o.rd_addr), 32'(v.rd_addr));
      check("a_rd_sel", s, 32'(o.rd_sel), 32'(v.rd_sel));
    end
    if (v.wr_en) begin
      check("wr_addr", s, 32'(o.wr_addr), 32'(v.wr_addr));
      check("wr_sel", s, 32'(o.wr_sel), 32'(v.wr_sel));
    end
  endtask

  // Call right after the accepting edge; leaves the design in DONE with start low.
  task automatic run_table(input int which, input int exp_clr, input int exp_wr);
    obs_t o;
    int   n_clr;
    int   n_wr;
    n_clr = 0;
    n_wr  = 0;
    for (int s = 0; s < tbl.size(); s++) begin
      o = get_obs(which);
      check_vec(o, tbl[s], s);
      if (o.acc_clr) n_clr++;
      if (o.wr_en) n_wr++;
      if (which == 0) bus0.start = tbl[s].start;
      else            bus1.start = tbl[s].start;
      tick();
    end
    check("acc_clr_pulses", which, 32'(n_clr), 32'(exp_clr));
    check("wr_en_pulses", which, 32'(n_wr), 32'(exp_wr));
  endtask

  task automatic check_zero0(input string nm);
    check({nm, "_busy"}, 0, 32'(bus0.busy), 32'd0);
    check({nm, "_done"}, 0, 32'(bus0.done), 32'd0);
    check({nm, "_w_addr"}, 0, 32'(bus0.w_addr), 32'd0);
    check({nm, "_a_rd_addr"}, 0, 32'(bus0.a_rd_addr), 32'd0);
    check({nm, "_a_rd_sel"}, 0, 32'(bus0.a_rd_sel), 32'd0);
    check({nm, "_acc_clr"}, 0, 32'(bus0.acc_clr), 32'd0);
    check({nm, "_acc_en"}, 0, 32'(bus0.acc_en), 32'd0);
    check({nm, "_bias_en"}, 0, 32'(bus0.bias_en), 32'd0);
    check({nm, "_act_en"}, 0, 32'(bus0.act_en), 32'd0);
    check({nm, "_wr_en"}, 0, 32'(bus0.wr_en), 32'd0);
    check({nm, "_wr_sel"}, 0, 32'(bus0.wr_sel), 32'd0);
    check({nm, "_wr_addr"}, 0, 32'(bus0.wr_addr), 32'd0);
  endtask

  initial begin
    int cnt;
    rst_n      = 1'b0;
    bus0.start = 1'b1;
    bus1.start = 1'b0;
    repeat (3) tick();
    check_zero0("reset");

    // Release with the button already held: must not start a run.
    rst_n = 1'b1;
    repeat (3) tick();
    check("held_start_busy", 0, 32'(bus0.busy), 32'd0);
    check("held_start_clr", 0, 32'(bus0.acc_clr), 32'd0);
    bus0.start = 1'b0;
    tick();

    // Full default run with a held button and a second press while busy.
    build(2, 4, 2);
    bus0.start = 1'b1;
    tick();
    run_table(0, 6, 6);

    // Restart straight from DONE, then reset at cycle 20 of that run.
    bus0.start = 1'b1;
    tick();
    check("restart_done", 0, 32'(bus0.done), 32'd0);
    check("restart_busy", 0, 32'(bus0.busy), 32'd1);
    check("restart_clr", 0, 32'(bus0.acc_clr), 32'd1);
    bus0.start = 1'b0;
    repeat (19) tick();
    check("pre_reset_busy", 0, 32'(bus0.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check_zero0("midrun");
    tick();
    check_zero0("midrun_hold");
    rst_n = 1'b1;
    tick();
    bus0.start = 1'b1;
    tick();
    run_table(0, 6, 6);

    // Reduced 2-1-1 network: 13-cycle run, then restart from DONE.
    build(2, 1, 1);
    bus1.start = 1'b1;
    tick();
    run_table(1, 2, 2);
    bus1.start = 1'b1;
    tick();
    check("small_restart_done", 1, 32'(bus1.done), 32'd0);
    check("small_restart_busy", 1, 32'(bus1.busy), 32'd1);
    bus1.start = 1'b0;
    cnt = 0;
    while (cnt < 40 && bus1.done !== 1'b1) begin
      tick();
      cnt++;
    end
    check("small_run_length", 1, 32'(cnt), 32'd13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
